pio_in_edge_capture: RTL and testbench

Parametrised Avalon-MM parallel input port, successor to the fixed 8-bit input PIO. It synchronises a `WIDTH`-bit external input bus and exposes the level on a memory-mapped data register. It also latches per-bit edge events into a sticky edge-capture register and raises a maskable level interrupt. It sits on the system interconnect as an Avalon slave, between board switches/buttons and the Nios II CPU.

---
 rtl/pio_pkg.sv | 17 +
 rtl/pio_in_bit_filter.sv | 60 ++++++
 rtl/pio_in_edge_capture.sv | 108 ++++++++++
 tb/tb_pio_in_edge_capture.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the parallel input port.
// Register map addresses and EDGE_TYPE encodings used by
// pio_in_edge_capture and its per-bit filter.
package pio_pkg;

  // Register map (word addresses on the 2-bit slave address)
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

  // EDGE_TYPE encodings
  localparam int PIO_EDGE_RISE = 0;
  localparam int PIO_EDGE_FALL = 1;
  localparam int PIO_EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_bit_filter.sv
// Per-bit input conditioning: SYNC_STAGES-flop synchroniser followed by an
// optional stability filter.
//   clk, reset : clock, synchronous active-high reset
//   din        : asynchronous external input bit
//   lvl        : filtered level (synchroniser output, or debounced level)
// Build option: define PIO_IN_DEBOUNCE_EN to add the debounce counter; a
// new level is accepted only after it has been seen on the synchroniser
// output for DEBOUNCE_CYCLES consecutive cycles.
module pio_in_bit_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;

  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DC_LAST = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          deb;

  assign cnt_inc = cnt + 1'b1;

  // Counter only runs while the synchroniser disagrees with the accepted
  // level; any agreement restarts the stability window.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync_out == deb) begin
      cnt <= '0;
    end else if (cnt_inc == DC_LAST) begin
      deb <= sync_out;
      cnt <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end

  assign lvl = deb;
`else
  assign lvl = sync_out;
`endif

endmodule

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM parallel input port with sticky edge capture and maskable
// level interrupt.
//   clk, reset          : clock, synchronous active-high reset
//   address, chipselect,
//   write, writedata    : slave write side (writes need chipselect && write)
//   readdata            : registered read data, loaded every cycle from the
//                         register selected by address
//   in_port             : asynchronous WIDTH-bit input bus
//   irq                 : registered |(edgecapture & irqmask)
// Map: 0 DATA (ro), 1 reserved, 2 IRQMASK (rw), 3 EDGECAPTURE (w1c).
// Build option: PIO_IN_DEBOUNCE_EN enables per-bit debounce in the filter.
module pio_in_edge_capture
  import pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = PIO_EDGE_RISE,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // Edges are suppressed until both lvl and lvl_d carry post-reset samples.
  localparam int PRIME_N = SYNC_STAGES + 1;
  localparam int PW      = $clog2(PRIME_N + 1);

  logic [WIDTH-1:0] lvl;
  logic [WIDTH-1:0] lvl_d;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      readdata_nxt;
  logic [PW-1:0]    prime_cnt;
  logic             primed;
  logic             wr_en;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_bit
      pio_in_bit_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_filt (
        .clk  (clk),
        .reset(reset),
        .din  (in_port[g]),
        .lvl  (lvl[g])
      );
    end
  endgenerate

  assign wr_en  = chipselect && write;
  assign wdata  = writedata[WIDTH-1:0];
  assign primed = (prime_cnt == PW'(PRIME_N));

  always_comb begin
    edge_ev = '0;
    case (EDGE_TYPE)
      PIO_EDGE_FALL: edge_ev = ~lvl & lvl_d;
      PIO_EDGE_ANY:  edge_ev = lvl ^ lvl_d;
      default:       edge_ev = lvl & ~lvl_d;
    endcase
  end

  assign edge_set = primed ? edge_ev : '0;
  assign edge_clr = (wr_en && address == PIO_ADDR_EDGE) ? wdata : '0;

  always_comb begin
    readdata_nxt = '0;
    case (address)
      PIO_ADDR_DATA:    readdata_nxt[WIDTH-1:0] = lvl;
      PIO_ADDR_IRQMASK: readdata_nxt[WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGE:    readdata_nxt[WIDTH-1:0] = edgecapture;
      default:          readdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_d       <= '0;
      prime_cnt   <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      lvl_d <= lvl;
      if (!primed) prime_cnt <= prime_cnt + 1'b1;
      if (wr_en && address == PIO_ADDR_IRQMASK) irqmask <= wdata;
      // Set is OR'd after the clear so a coincident new edge survives.
      edgecapture <= (edgecapture & ~edge_clr) | edge_set;
      readdata    <= readdata_nxt;
      irq         <= |(edgecapture & irqmask);
    end
  end

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Bench for pio_in_edge_capture: three instances (rising, falling, any edge)
// share one bus and input; a history-based model predicts readdata and irq.
module tb_pio_in_edge_capture;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [W-1:0] in_port = 8'hFF;
  logic [31:0] rd_dut [3];
  logic        irq_dut [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      pio_in_edge_capture #(
        .WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(g), .DEBOUNCE_CYCLES(DC)
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write     (write),
        .writedata (writedata),
        .readdata  (rd_dut[g]),
        .in_port   (in_port),
        .irq       (irq_dut[g])
      );
    end
  endgenerate

  // ---------------- reference model ----------------
  // iq: input samples seen at each edge, newest first (ok=0 for reset edges)
  // lh: filtered level after each edge, newest first
  typedef struct packed { bit ok; logic [W-1:0] v; } samp_t;
  samp_t        iq[$];
  samp_t        lh[$];
  logic [W-1:0] m_ec   [3];
  logic [W-1:0] m_mask [3];
  logic [31:0]  m_rd   [3];
  logic         m_irq  [3];
  logic [W-1:0] m_deb;
  int           m_run  [W];
  bit           m_valid = 0;

  task automatic model_step();
    bit           o_ok;
    logic [W-1:0] o_lvl, o_lvld, o_sync, ev, clr, nl;
    samp_t        s;
    o_ok   = lh[0].ok && lh[1].ok;
    o_lvl  = lh[0].v;
    o_lvld = lh[1].v;
    o_sync = iq[S-1].v;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_ec[i] = '0; m_mask[i] = '0; m_rd[i] = '0; m_irq[i] = 1'b0;
      end
      m_deb = '0;
      for (int b = 0; b < W; b++) m_run[b] = 0;
      iq.delete(); lh.delete();
      for (int k = 0; k < S; k++) iq.push_back('0);
      lh.push_back('0); lh.push_back('0);
      m_valid = 1;
      return;
    end
    clr = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int i = 0; i < 3; i++) begin
      case (address)
        2'd0: m_rd[i] = {24'd0, o_lvl};
        2'd2: m_rd[i] = {24'd0, m_mask[i]};
        2'd3: m_rd[i] = {24'd0, m_ec[i]};
        default: m_rd[i] = '0;
      endcase
      m_irq[i] = |(m_ec[i] & m_mask[i]);
      if (i == 0)      ev = o_lvl & ~o_lvld;
      else if (i == 1) ev = ~o_lvl & o_lvld;
      else             ev = o_lvl ^ o_lvld;
      if (!o_ok) ev = '0;
      m_ec[i] = (m_ec[i] & ~clr) | ev;
      if (chipselect && write && address == 2'd2) m_mask[i] = writedata[W-1:0];
    end
    s.ok = 1'b1; s.v = in_port;
    iq.push_front(s);
    void'(iq.pop_back());
`ifdef PIO_IN_DEBOUNCE_EN
    // A level is accepted after DC consecutive disagreeing sync samples.
    for (int b = 0; b < W; b++) begin
      if (o_sync[b] == m_deb[b]) m_run[b] = 0;
      else if (m_run[b] + 1 == DC) begin m_deb[b] = o_sync[b]; m_run[b] = 0; end
      else m_run[b]++;
    end
    nl = m_deb;
`else
    nl = iq[S-1].v;
`endif
    s.ok = iq[S-1].ok; s.v = nl;
    lh.push_front(s);
    void'(lh.pop_back());
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    if (!m_valid) return;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_readdata[%0d]", i), rd_dut[i], m_rd[i]);
      chk($sformatf("model_irq[%0d]", i), {31'd0, irq_dut[i]}, {31'd0, m_irq[i]});
    end
  endtask

  // One cycle: the model advances on the edge, DUT outputs sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    cyc();
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < S; k++) iq.push_back('0);
    lh.push_back('0); lh.push_back('0);

`ifndef PIO_IN_DEBOUNCE_EN
    // Reset with inputs high: DATA fills, no spurious edge.
    repeat (3) cyc();
    reset = 1'b0;
    repeat (5) cyc();
    chk("data_after_fill", rd_dut[0], 32'h0000_00FF);
    address = 2'd3; cyc();
    for (int i = 0; i < 3; i++) begin
      chk("edge_after_reset", rd_dut[i], 32'h0);
      chk("irq_after_reset", {31'd0, irq_dut[i]}, 32'h0);
    end
    address = 2'd1; cyc(); chk("reserved_reads0", rd_dut[0], 32'h0);
    address = 2'd2; cyc(); chk("mask_after_reset", rd_dut[0], 32'h0);

    // Rising edge on bit0 with mask 01.
    bus_wr(2'd2, 32'h1);
    in_port = 8'hFE; repeat (4) cyc();
    bus_wr(2'd3, 32'hFF);
    address = 2'd3; repeat (3) cyc();
    in_port = 8'hFF;
    cyc(); cyc(); cyc();              // E0, E1, E2
    chk("rise_irq_before_E3", {31'd0, irq_dut[0]}, 32'h0);
    cyc();                            // E3
    chk("rise_edge_E3", rd_dut[0], 32'h1);
    chk("rise_irq_E3", {31'd0, irq_dut[0]}, 32'h1);
    chipselect = 1'b1; write = 1'b1; writedata = 32'h1;
    cyc();                            // clear at N
    chipselect = 1'b0; write = 1'b0;
    chk("irq_still_high_N", {31'd0, irq_dut[0]}, 32'h1);
    cyc();                            // N+1
    chk("irq_low_N1", {31'd0, irq_dut[0]}, 32'h0);
    chk("edge_cleared", rd_dut[0], 32'h0);

    // Clear of bit3 coincident with a new rise on bit3: set wins.
    in_port = 8'hF7; repeat (4) cyc();
    in_port = 8'hFF; repeat (4) cyc();
    in_port = 8'hF7; repeat (4) cyc();
    in_port = 8'hFF;
    cyc(); cyc();                     // E0, E1
    chipselect = 1'b1; write = 1'b1; address = 2'd3; writedata = 32'h8;
    cyc();                            // E2: set and clear together
    chipselect = 1'b0; write = 1'b0;
    cyc();
    chk("set_wins_bit3", rd_dut[0], 32'h8);

    // Any-edge, mask 0, bit5 toggled twice.
    bus_wr(2'd3, 32'hFF);
    bus_wr(2'd2, 32'h0);
    address = 2'd3;
    in_port = 8'hDF; repeat (4) cyc();
    in_port = 8'hFF; repeat (4) cyc();
    chk("any_edge_bit5", rd_dut[2], 32'h20);
    chk("any_irq_masked", {31'd0, irq_dut[2]}, 32'h0);
    bus_wr(2'd2, 32'h20);
    address = 2'd3;
    chk("mask_irq_N", {31'd0, irq_dut[2]}, 32'h0);
    cyc();
    chk("mask_irq_N1", {31'd0, irq_dut[2]}, 32'h1);

    // Reset one cycle after an edge lands in EDGECAPTURE.
    in_port = 8'h7F;
    cyc(); cyc(); cyc();              // fall on bit7 captured at E2
    reset = 1'b1; repeat (2) cyc();
    reset = 1'b0;
    address = 2'd3; repeat (5) cyc();
    chk("reset_clears_edge", rd_dut[1], 32'h0);
    chk("reset_clears_irq", {31'd0, irq_dut[2]}, 32'h0);
    address = 2'd2; cyc();
    chk("reset_clears_mask", rd_dut[2], 32'h0);
`else
    // Debounce: a 3-cycle glitch is filtered, a 6-cycle level is accepted.
    in_port = 8'hFD;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (12) cyc();
    bus_wr(2'd3, 32'hFF);
    address = 2'd3;
    in_port = 8'hFF; repeat (3) cyc();
    in_port = 8'hFD; repeat (10) cyc();
    chk("glitch_no_edge", rd_dut[0], 32'h0);
    address = 2'd0; cyc();
    chk("glitch_data", rd_dut[0], 32'hFD);
    in_port = 8'hFF; repeat (14) cyc();
    chk("debounced_data", rd_dut[0], 32'hFF);
    address = 2'd3; cyc();
    chk("debounced_edge", rd_dut[0], 32'h2);
`endif

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W-1));
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) == 0);
      write      = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      reset      = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0; chipselect = 1'b0; write = 1'b0;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
